// File: rtl/axi_rd_responder.sv
// AXI4 read-channel responder: serves FIXED/INCR/WRAP read bursts from an internal
// word-addressed memory, with a side preload port for filling it before execution.
module axi_rd_responder #(
   parameter int                    ID_WIDTH   = 13,
   parameter int                    ADDR_WIDTH = 64,
   parameter int                    DATA_WIDTH = 64,
   parameter int                    DEPTH      = 4096,
   parameter logic [ADDR_WIDTH-1:0] BASE       = '0,
   parameter int                    LATENCY    = 1
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [ID_WIDTH-1:0]      s_axi_arid,
   input  logic [ADDR_WIDTH-1:0]    s_axi_araddr,
   input  logic [7:0]               s_axi_arlen,
   input  logic [2:0]               s_axi_arsize,
   input  logic [1:0]               s_axi_arburst,
   input  logic                     s_axi_arvalid,
   output logic                     s_axi_arready,
   output logic [ID_WIDTH-1:0]      s_axi_rid,
   output logic [DATA_WIDTH-1:0]    s_axi_rdata,
   output logic [1:0]               s_axi_rresp,
   output logic                     s_axi_rlast,
   output logic                     s_axi_rvalid,
   input  logic                     s_axi_rready,
   input  logic                     init_we,
   input  logic [$clog2(DEPTH)-1:0] init_addr,
   input  logic [DATA_WIDTH-1:0]    init_data
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = (LATENCY > 2) ? $clog2(LATENCY) : 1;
   localparam logic [ADDR_WIDTH-1:0] SPAN = ADDR_WIDTH'(DEPTH) << 3;

   localparam logic [1:0] B_FIXED     = 2'b00;
   localparam logic [1:0] B_WRAP      = 2'b10;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {S_IDLE, S_DELAY, S_BURST} state_e;

   state_e                  state_q, state_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [ID_WIDTH-1:0]     id_q, id_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [7:0]              len_q, len_d;
   logic [2:0]              size_q, size_d;
   logic [1:0]              burst_q, burst_d;
   logic                    err_q, err_d;
   logic [7:0]              beat_q, beat_d;
   logic                    arready_q, arready_d;
   logic                    rvalid_q, rvalid_d;
   logic [ID_WIDTH-1:0]     rid_q, rid_d;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic [1:0]              rresp_q, rresp_d;
   logic                    rlast_q, rlast_d;

   logic                    cap;
   logic [ADDR_WIDTH-1:0]   fetch_addr;
   logic [7:0]              fetch_beat;
   logic                    borrow;
   logic [ADDR_WIDTH-1:0]   off;
   logic                    beat_bad;

   logic [DATA_WIDTH-1:0]   mem [DEPTH];

   // Request-level errors are decided once from the AR fields and apply to every beat.
   logic [ADDR_WIDTH-1:0]   ar_step;
   logic                    ar_wrap_bad;
   logic                    ar_err;

   assign ar_step     = ADDR_WIDTH'(1) << s_axi_arsize;
   assign ar_wrap_bad = (s_axi_arburst == B_WRAP) &&
                        (!(s_axi_arlen inside {8'd1, 8'd3, 8'd7, 8'd15}) ||
                         ((s_axi_araddr & (ar_step - ADDR_WIDTH'(1))) != '0));
   assign ar_err      = (s_axi_arburst == 2'b11) || (s_axi_arsize > 3'd3) || ar_wrap_bad;

   function automatic logic [ADDR_WIDTH-1:0] next_addr(
      input logic [ADDR_WIDTH-1:0] addr,
      input logic [7:0]            len,
      input logic [2:0]            size,
      input logic [1:0]            burst
   );
      logic [ADDR_WIDTH-1:0] step;
      logic [ADDR_WIDTH-1:0] wsize;
      logic [ADDR_WIDTH-1:0] lower;
      step  = ADDR_WIDTH'(1) << size;
      wsize = (ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size;
      lower = addr & ~(wsize - ADDR_WIDTH'(1));
      case (burst)
         B_FIXED: next_addr = addr;
         B_WRAP:  next_addr = lower + ((addr + step - lower) & (wsize - ADDR_WIDTH'(1)));
         default: next_addr = addr + step;
      endcase
   endfunction

   // NOTE: every signal driven here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      id_d       = id_q;
      addr_d     = addr_q;
      len_d      = len_q;
      size_d     = size_q;
      burst_d    = burst_q;
      err_d      = err_q;
      beat_d     = beat_q;
      rid_d      = rid_q;
      rdata_d    = rdata_q;
      rresp_d    = rresp_q;
      rlast_d    = rlast_q;
      cap        = 1'b0;
      fetch_addr = addr_q;
      fetch_beat = '0;

      case (state_q)
         S_IDLE: begin
            if (s_axi_arvalid && arready_q) begin
               id_d    = s_axi_arid;
               addr_d  = s_axi_araddr;
               len_d   = s_axi_arlen;
               size_d  = s_axi_arsize;
               burst_d = s_axi_arburst;
               err_d   = ar_err;
               if (LATENCY == 1) begin
                  state_d    = S_BURST;
                  cap        = 1'b1;
                  fetch_addr = s_axi_araddr;
               end else begin
                  state_d = S_DELAY;
                  cnt_d   = CW'(LATENCY > 1 ? LATENCY - 2 : 0);
               end
            end
         end
         S_DELAY: begin
            if (cnt_q == '0) begin
               state_d    = S_BURST;
               cap        = 1'b1;
               fetch_addr = addr_q;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_BURST: begin
            if (s_axi_rready) begin
               if (rlast_q) begin
                  state_d = S_IDLE;
               end else begin
                  cap        = 1'b1;
                  fetch_addr = next_addr(addr_q, len_q, size_q, burst_q);
                  fetch_beat = beat_q + 8'd1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      // The borrow flags addresses below BASE; the compare catches the top of the window.
      {borrow, off} = {1'b0, fetch_addr} - {1'b0, BASE};
      beat_bad      = err_d || borrow || (off >= SPAN);

      if (cap) begin
         addr_d  = fetch_addr;
         beat_d  = fetch_beat;
         rid_d   = id_d;
         rlast_d = (fetch_beat == len_d);
         rresp_d = beat_bad ? RESP_SLVERR : RESP_OKAY;
         rdata_d = beat_bad ? '0 : mem[off[AW+2:3]];
      end

      arready_d = (state_d == S_IDLE);
      rvalid_d  = (state_d == S_BURST);
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         id_q      <= '0;
         addr_q    <= '0;
         len_q     <= '0;
         size_q    <= '0;
         burst_q   <= '0;
         err_q     <= 1'b0;
         beat_q    <= '0;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rid_q     <= '0;
         rdata_q   <= '0;
         rresp_q   <= '0;
         rlast_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         id_q      <= id_d;
         addr_q    <= addr_d;
         len_q     <= len_d;
         size_q    <= size_d;
         burst_q   <= burst_d;
         err_q     <= err_d;
         beat_q    <= beat_d;
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
         rid_q     <= rid_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
         rlast_q   <= rlast_d;
      end
   end

   // NOTE: the memory array has no reset; preloaded contents survive reset_n.
   always_ff @(posedge clk) begin
      if (init_we) mem[init_addr] <= init_data;
   end

   assign s_axi_arready = arready_q;
   assign s_axi_rvalid  = rvalid_q;
   assign s_axi_rid     = rid_q;
   assign s_axi_rdata   = rdata_q;
   assign s_axi_rresp   = rresp_q;
   assign s_axi_rlast   = rlast_q;

endmodule

// File: tb/tb_axi_rd_responder.sv
// Self-checking bench for axi_rd_responder: directed vector table, hand-written corner
// sequences (latency, mid-burst reset) and randomized bursts against a reference model.
module tb_axi_rd_responder;

   localparam int          DEPTH = 4096;
   localparam logic [63:0] BASE  = 64'h0000_0000_8000_0000;
   localparam logic [63:0] SPAN  = 64'(8 * DEPTH);
   localparam logic [15:0] E     = 16'hFFFF;   // table marker: beat must be SLVERR with zero data

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   always #5 clk = ~clk;

   logic [12:0] arid;
   logic [63:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic        arvalid, arvalid2, rready, rready2;
   logic        init_we;
   logic [11:0] init_addr;
   logic [63:0] init_data;

   logic        arready, rlast, rvalid, arready2, rlast2, rvalid2;
   logic [12:0] rid, rid2;
   logic [63:0] rdata, rdata2;
   logic [1:0]  rresp, rresp2;

   axi_rd_responder #(.DEPTH(DEPTH), .BASE(BASE), .LATENCY(1)) u_dut (
      .clk(clk), .reset_n(reset_n),
      .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen),
      .s_axi_arsize(arsize), .s_axi_arburst(arburst),
      .s_axi_arvalid(arvalid), .s_axi_arready(arready),
      .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
      .s_axi_rvalid(rvalid), .s_axi_rready(rready),
      .init_we(init_we), .init_addr(init_addr), .init_data(init_data)
   );

   axi_rd_responder #(.DEPTH(DEPTH), .BASE(BASE), .LATENCY(3)) u_lat3 (
      .clk(clk), .reset_n(reset_n),
      .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen),
      .s_axi_arsize(arsize), .s_axi_arburst(arburst),
      .s_axi_arvalid(arvalid2), .s_axi_arready(arready2),
      .s_axi_rid(rid2), .s_axi_rdata(rdata2), .s_axi_rresp(rresp2), .s_axi_rlast(rlast2),
      .s_axi_rvalid(rvalid2), .s_axi_rready(rready2),
      .init_we(init_we), .init_addr(init_addr), .init_data(init_data)
   );

   int          checks = 0;
   int          failures = 0;
   logic [63:0] mdl_mem [DEPTH];
   logic [63:0] obs_data [$];
   logic [1:0]  obs_resp [$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] pat(input int i);
      return (i < 8) ? 64'h1000 + 64'(i) : 64'hC0DE_0000_0000_0000 | 64'(i);
   endfunction

   // Reference model: beat k address computed directly from the start address.
   function automatic logic [63:0] m_addr(input logic [63:0] start, input logic [7:0] len,
                                          input logic [2:0] size, input logic [1:0] burst,
                                          input int k);
      logic [63:0] step, wsize, lower;
      step  = 64'd1 << size;
      wsize = (64'(len) + 64'd1) * step;
      lower = start - (start % wsize);
      case (burst)
         2'b00:   return start;
         2'b10:   return lower + ((start - lower + 64'(k) * step) % wsize);
         default: return start + 64'(k) * step;
      endcase
   endfunction

   function automatic logic m_err(input logic [63:0] start, input logic [7:0] len,
                                  input logic [2:0] size, input logic [1:0] burst,
                                  input logic [63:0] addr);
      logic bad_req;
      bad_req = (burst == 2'b11) || (size > 3'd3) ||
                (burst == 2'b10 && (!(len inside {8'd1, 8'd3, 8'd7, 8'd15}) ||
                                    (start % (64'd1 << size)) != 64'd0));
      return bad_req || (addr < BASE) || (addr >= BASE + SPAN);
   endfunction

   task automatic preload(input int idx, input logic [63:0] d);
      init_we   = 1'b1;
      init_addr = 12'(idx);
      init_data = d;
      @(posedge clk); #1;
      init_we   = 1'b0;
      mdl_mem[idx] = d;
   endtask

   // Issues one AR on the LATENCY=1 instance, collects beats into obs_*, and checks
   // protocol rules: rvalid continuity, stall stability, rid, rlast position, turnaround.
   task automatic run_burst(input logic [12:0] id, input logic [63:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input int mode);
      int          k, cyc, w;
      logic        stalled;
      logic [63:0] h_data;
      logic [1:0]  h_resp;
      logic        h_last;
      logic [12:0] h_id;
      obs_data.delete();
      obs_resp.delete();
      w = 0;
      while (!arready && w < 50) begin @(posedge clk); #1; w++; end
      check("arready_before_ar", arready, 1);
      arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst;
      arvalid = 1'b1;
      @(posedge clk); #1;
      arvalid = 1'b0;
      k = 0; cyc = 0; stalled = 1'b0;
      h_data = '0; h_resp = '0; h_last = 1'b0; h_id = '0;
      while (k <= int'(len) && cyc < 400) begin
         check($sformatf("rvalid[%0d]", k), rvalid, 1);
         if (stalled) begin
            check($sformatf("hold_data[%0d]", k), rdata, h_data);
            check($sformatf("hold_resp[%0d]", k), rresp, h_resp);
            check($sformatf("hold_last[%0d]", k), rlast, h_last);
            check($sformatf("hold_id[%0d]", k), rid, h_id);
         end
         case (mode)
            0:       rready = 1'b1;
            1:       rready = (cyc % 2 == 0);
            default: rready = 1'($urandom_range(0, 1));
         endcase
         stalled = 1'b0;
         if (rvalid && rready) begin
            check($sformatf("rid[%0d]", k), rid, id);
            check($sformatf("rlast[%0d]", k), rlast, (k == int'(len)));
            obs_data.push_back(rdata);
            obs_resp.push_back(rresp);
            k++;
         end else if (rvalid) begin
            stalled = 1'b1;
            h_data = rdata; h_resp = rresp; h_last = rlast; h_id = rid;
         end
         @(posedge clk); #1;
         cyc++;
      end
      rready = 1'b0;
      check("beat_count", 64'(k), 64'(len) + 64'd1);
      check("rvalid_after_last", rvalid, 0);
      check("arready_after_last", arready, 1);
   endtask

   typedef struct packed {
      logic [12:0]       id;
      logic [63:0]       off;
      logic [7:0]        len;
      logic [2:0]        size;
      logic [1:0]        burst;
      logic [1:0]        mode;
      logic [7:0][15:0]  exp_word;   // beat b expectation lives at index 7-b
   } vec_t;

   localparam int NV = 10;
   vec_t vecs [NV];

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;
      arvalid = 1'b0; arvalid2 = 1'b0; rready = 1'b0; rready2 = 1'b1;
      init_we = 1'b0; init_addr = '0; init_data = '0;

      vecs[0] = '{13'h5,    64'h14,             8'd7, 3'd2, 2'b10, 2'd0,
                  {16'd2, 16'd3, 16'd3, 16'd0, 16'd0, 16'd1, 16'd1, 16'd2}};
      vecs[1] = '{13'h1A,   64'h8,              8'd3, 3'd3, 2'b01, 2'd1,
                  {16'd1, 16'd2, 16'd3, 16'd4, 64'd0}};
      vecs[2] = '{13'h1FFF, SPAN - 64'd8,       8'd1, 3'd3, 2'b01, 2'd0,
                  {16'd4095, E, 96'd0}};
      vecs[3] = '{13'h3,    64'h0,              8'd2, 3'd3, 2'b10, 2'd0,
                  {E, E, E, 80'd0}};
      vecs[4] = '{13'h7,    64'h18,             8'd3, 3'd3, 2'b00, 2'd2,
                  {16'd3, 16'd3, 16'd3, 16'd3, 64'd0}};
      vecs[5] = '{13'h9,    64'h0,              8'd1, 3'd3, 2'b11, 2'd0,
                  {E, E, 96'd0}};
      vecs[6] = '{13'hA,    64'h20,             8'd0, 3'd4, 2'b01, 2'd0,
                  {E, 112'd0}};
      vecs[7] = '{13'hB,    64'h4,              8'd1, 3'd3, 2'b10, 2'd0,
                  {E, E, 96'd0}};
      vecs[8] = '{13'hC,    64'h30,             8'd3, 3'd3, 2'b10, 2'd1,
                  {16'd6, 16'd7, 16'd4, 16'd5, 64'd0}};
      vecs[9] = '{13'hD,    64'hFFFF_FFFF_FFFF_FFF8, 8'd1, 3'd3, 2'b01, 2'd0,
                  {E, 16'd0, 96'd0}};

      // Reset state and first-edge arready.
      repeat (3) @(posedge clk);
      #1;
      check("rst_arready", arready, 0);
      check("rst_rvalid", rvalid, 0);
      check("rst_rdata", rdata, 0);
      check("rst_rid", rid, 0);
      check("rst_rresp", rresp, 0);
      check("rst_rlast", rlast, 0);
      check("rst_rvalid_lat3", rvalid2, 0);
      reset_n = 1'b1;
      #1;
      check("arready_before_first_edge", arready, 0);
      @(posedge clk); #1;
      check("arready_first_edge", arready, 1);
      check("arready_first_edge_lat3", arready2, 1);

      for (int i = 0; i < DEPTH; i++) preload(i, pat(i));

      // Directed vector table.
      for (int v = 0; v < NV; v++) begin
         run_burst(vecs[v].id, BASE + vecs[v].off, vecs[v].len, vecs[v].size,
                   vecs[v].burst, int'(vecs[v].mode));
         for (int b = 0; b <= int'(vecs[v].len) && b < obs_data.size(); b++) begin
            logic [15:0] w;
            w = vecs[v].exp_word[7 - b];
            check($sformatf("vec%0d_data[%0d]", v, b), obs_data[b],
                  (w == E) ? 64'd0 : pat(int'(w)));
            check($sformatf("vec%0d_resp[%0d]", v, b), obs_resp[b],
                  (w == E) ? 64'd2 : 64'd0);
         end
      end

      // LATENCY = 3 instance: first beat exactly three cycles after the handshake.
      arid = 13'h33; araddr = BASE + 64'h28; arlen = 8'd0; arsize = 3'd3; arburst = 2'b01;
      check("lat3_arready", arready2, 1);
      arvalid2 = 1'b1;
      @(posedge clk); #1;
      arvalid2 = 1'b0;
      check("lat3_rvalid_t1", rvalid2, 0);
      check("lat3_arready_t1", arready2, 0);
      @(posedge clk); #1;
      check("lat3_rvalid_t2", rvalid2, 0);
      @(posedge clk); #1;
      check("lat3_rvalid_t3", rvalid2, 1);
      check("lat3_rdata", rdata2, mdl_mem[5]);
      check("lat3_rid", rid2, 13'h33);
      check("lat3_rlast", rlast2, 1);
      check("lat3_rresp", rresp2, 0);
      @(posedge clk); #1;
      check("lat3_rvalid_t4", rvalid2, 0);
      check("lat3_arready_t4", arready2, 1);

      // Randomized bursts against the reference model.
      for (int n = 0; n < 150; n++) begin
         logic [63:0] a, ea, ed;
         logic [7:0]  l;
         logic [2:0]  s;
         logic [1:0]  b;
         logic        er;
         int          r;
         if ($urandom_range(0, 3) == 0) preload(int'($urandom_range(0, DEPTH - 1)), {$urandom, $urandom});
         r = int'($urandom_range(0, 9));
         b = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
         s = 3'($urandom_range(0, 3));
         if ($urandom_range(0, 9) == 0) s = 3'd4;
         if (b == 2'b10 && $urandom_range(0, 4) != 0) begin
            case ($urandom_range(0, 3))
               0:       l = 8'd1;
               1:       l = 8'd3;
               2:       l = 8'd7;
               default: l = 8'd15;
            endcase
         end else begin
            l = 8'($urandom_range(0, 15));
         end
         a = BASE - 64'd64 + 64'($urandom_range(0, 8 * DEPTH + 128));
         if (b == 2'b10 && $urandom_range(0, 4) != 0) a = a & ~((64'd1 << s) - 64'd1);
         run_burst(13'($urandom), a, l, s, b, int'($urandom_range(0, 2)));
         for (int k = 0; k <= int'(l) && k < obs_data.size(); k++) begin
            ea = m_addr(a, l, s, b, k);
            er = m_err(a, l, s, b, ea);
            ed = er ? 64'd0 : mdl_mem[12'((ea - BASE) >> 3)];
            check($sformatf("rnd%0d_data[%0d]", n, k), obs_data[k], ed);
            check($sformatf("rnd%0d_resp[%0d]", n, k), obs_resp[k], er ? 64'd2 : 64'd0);
         end
      end

      // Reset in the middle of an 8-beat burst.
      arid = 13'h44; araddr = BASE; arlen = 8'd7; arsize = 3'd3; arburst = 2'b01;
      check("mid_rst_arready", arready, 1);
      arvalid = 1'b1;
      rready  = 1'b1;
      @(posedge clk); #1;
      arvalid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("mid_rst_beat%0d", i), rvalid, 1);
         @(posedge clk); #1;
      end
      #2 reset_n = 1'b0;
      #1;
      check("mid_rst_rvalid", rvalid, 0);
      check("mid_rst_arready_low", arready, 0);
      check("mid_rst_rdata", rdata, 0);
      check("mid_rst_rlast", rlast, 0);
      check("mid_rst_rid", rid, 0);
      check("mid_rst_rresp", rresp, 0);
      rready = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      @(posedge clk); #1;
      check("post_rst_arready", arready, 1);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("post_rst_no_beat%0d", i), rvalid, 0);
         @(posedge clk); #1;
      end
      run_burst(13'h45, BASE + 64'h28, 8'd0, 3'd3, 2'b01, 0);
      if (obs_data.size() > 0) begin
         check("post_rst_data", obs_data[0], mdl_mem[5]);
         check("post_rst_resp", obs_resp[0], 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/axi_rd_responder.md
# axi_rd_responder

AXI4 read-channel responder (slave) that serves instruction-fetch and data read bursts from an internal word-addressed memory. It sits on the far side of the fetch unit's AR/R channels as the bus-side memory model for simulation and small FPGA builds. It accepts one AR request at a time, generates FIXED/INCR/WRAP beat addresses, and returns R beats with `rid`, `rresp` and `rlast`. A side preload port fills the memory before execution.

## Interface
- `ID_WIDTH`, 13: AXI ID width.
- `ADDR_WIDTH`, 64: address width.
- `DATA_WIDTH`, 64: data width. Fixed at 64; `arsize` > 3 is illegal.
- `DEPTH`, 4096: memory size in 64-bit words.
- `BASE`, 64'h0: byte address of word 0.
- `LATENCY`, 1: cycles from AR handshake to the first R beat. Must be ≥ 1.
- `clk` in 1: clock. Rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `s_axi_arid/araddr/arlen/arsize/arburst` in ID_WIDTH/ADDR_WIDTH/8/3/2: read request.
- `s_axi_arvalid` in 1; `s_axi_arready` out 1.
- `s_axi_rid` out ID_WIDTH; `s_axi_rdata` out 64; `s_axi_rresp` out 2; `s_axi_rlast` out 1.
- `s_axi_rvalid` out 1; `s_axi_rready` in 1.
- `init_we` in 1; `init_addr` in $clog2(DEPTH) (word index); `init_data` in 64: preload write port.

## Operation
- FSM states:
  - IDLE: `arready` = 1.
  - DELAY: counts `LATENCY`-1 cycles.
  - BURST: `rvalid` = 1.
- FSM transitions:
  - IDLE→DELAY on AR handshake. Goes straight to BURST when `LATENCY` = 1.
  - DELAY→BURST when the count expires.
  - BURST→IDLE on the handshake of the last beat.
- On AR handshake, latch `arid`, `araddr`, `arlen`, `arsize`, `arburst`. Beat counter = `arlen`+1.
- Beat address for beat k+1 (step = 1<<`arsize`):
  - FIXED (00): same address as beat k.
  - INCR (01): beat k address + step, 64-bit wrap-around.
  - WRAP (10): wrap boundary size = (`arlen`+1)·step; lower = addr & ~(size-1). Next = lower + ((addr + step − lower) mod size).
  - Reserved (11): treated as INCR with SLVERR.
- Beat data: the full 64-bit word at (addr − BASE)>>3. The master selects byte lanes; no lane shifting.
- Per-beat `rresp` = SLVERR (2'b10), `rdata` = 0 when any of these holds:
  - the address is out of range (< BASE or ≥ BASE+8·DEPTH);
  - `arburst` = 11;
  - `arsize` > 3;
  - WRAP with `arlen` ∉ {1,3,7,15}, or a WRAP start address not aligned to step.
- Otherwise `rresp` = OKAY (00).
- Error bursts still return exactly `arlen`+1 beats.
- `rid` = latched `arid` for every beat. `rlast` = 1 only on beat `arlen`.
- Preload: `init_we` writes `init_data` at `init_addr` on the clock edge. It is legal in any state. Memory contents are not cleared by reset.

## Timing
- Reset values (asynchronous, while `reset_n` = 0):
  - `arready` = 0.
  - `rvalid`, `rlast`, `rdata`, `rid`, `rresp` = 0.
  - FSM = IDLE.
  - `arready` = 1 from the first clock edge after `reset_n` rises.
- AR handshake in cycle T → first `rvalid` = 1 in cycle T+`LATENCY`. `arready` = 0 from T+1 until IDLE.
- R outputs are registered:
  - Beat data is read from memory into `rdata` when BURST is entered and on each non-last R handshake.
  - The next beat is presented the cycle after the handshake, so back-to-back beats occur with `rready` held at 1.
- While `rvalid` = 1 and `rready` = 0: `rdata`, `rresp`, `rid`, `rlast` hold stable. `rvalid` never drops before the handshake.
- Last-beat handshake in cycle L → `rvalid` = 0 and `arready` = 1 in L+1. The minimum AR-to-AR spacing is `arlen`+1+`LATENCY` cycles.
- A preload write in the same edge as a beat capture to the same word returns the old data.
- Reset mid-burst: the burst is abandoned and outputs go to reset values immediately. No partial beats follow after release.

## Test plan
- WRAP burst:
  - Stimulus: preload words 0..7 = 0x1000+i; AR id 0x5, addr BASE+0x14, len 7, size 2, WRAP.
  - Response: 8 beats with data words 2,3,3,0,0,1,1,2; `rid` = 5; OKAY; `rlast` only on beat 8.
- INCR with backpressure:
  - Stimulus: INCR len 3, size 3, addr BASE+0x8; `rready` pattern 1,0,1,0,...
  - Response: data words 1,2,3,4. Each stall holds `rdata`/`rlast` stable; `arready` = 1 the cycle after the 4th handshake.
- Range error:
  - Stimulus: INCR len 1, size 3, addr BASE+8·DEPTH−8.
  - Response: beat 0 is OKAY with the last word; beat 1 is SLVERR with `rdata` = 0 and `rlast` = 1.
- Illegal WRAP:
  - Stimulus: WRAP `arlen` = 2.
  - Response: 3 beats, all SLVERR, `rdata` = 0.
- Latency:
  - Stimulus: `LATENCY` = 3; AR handshake at cycle T.
  - Response: `rvalid` = 0 at T+1 and T+2, `rvalid` = 1 at T+3.
- Reset mid-burst:
  - Stimulus: assert `reset_n` = 0 after beat 2 of an 8-beat burst.
  - Response: `rvalid` = 0 asynchronously; after release, `arready` = 1, a new AR (len 0) returns one beat, and preloaded contents are intact.
